// File: rtl/sargantana_icache_refill_ctrl.sv
// sargantana_icache_refill_ctrl: icache miss refill from L2 into a victim way; ICACHE_REFILL_BYPASS_EN adds a same-cycle line bypass
module sargantana_icache_refill_ctrl #(
  parameter int N_WAY  = 4,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 7
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [IDX_W-1:0]  miss_idx_i,
  input  logic [N_WAY-1:0]  way_valid_i,
  input  logic              flush_i,
  output logic              l2_req_valid_o,
  input  logic              l2_req_ready_i,
  output logic [IDX_W-1:0]  l2_req_idx_o,
  input  logic              l2_beat_valid_i,
  input  logic [BEAT_W-1:0] l2_beat_data_i,
  output logic [N_WAY-1:0]  mem_req_o,
  output logic              mem_we_o,
  output logic [IDX_W-1:0]  mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              refill_done_o,
  output logic [N_WAY-1:0]  refill_way_o
`ifdef ICACHE_REFILL_BYPASS_EN
  ,
  output logic              bypass_valid_o,
  output logic [LINE_W-1:0] bypass_line_o
`endif
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_WAY-1:0] victim_q, victim_d, rr_q, rr_d, free_way;
  logic use_rr_q, use_rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic last_beat;
  assign free_way = ~way_valid_i & (way_valid_i + N_WAY'(1));
  assign last_beat = l2_beat_valid_i && cnt_q == CW'(BEATS - 1);
  assign l2_req_idx_o = idx_q;
  assign mem_addr_o = idx_q;
  assign mem_data_o = buf_q;
`ifdef ICACHE_REFILL_BYPASS_EN
  assign bypass_valid_o = state_q == WRITE && !flush_i;
  assign bypass_line_o = buf_q;
`endif
  // State, index, victim, round-robin pointer, beat counter and line buffer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      victim_q <= '0;
      use_rr_q <= 1'b0;
      rr_q     <= N_WAY'(1);
      cnt_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      use_rr_q <= use_rr_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
    end
  end
  // Next state and outputs; a flushed beat is counted but never stored
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    victim_d       = victim_q;
    use_rr_d       = use_rr_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    miss_ready_o   = 1'b0;
    l2_req_valid_o = 1'b0;
    mem_req_o      = '0;
    mem_we_o       = 1'b0;
    refill_done_o  = 1'b0;
    refill_way_o   = '0;
    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          idx_d    = miss_idx_i;
          use_rr_d = ~|free_way;
          victim_d = |free_way ? free_way : rr_q;
          state_d  = REQ;
        end
      end
      REQ: begin
        l2_req_valid_o = 1'b1;
        cnt_d   = l2_req_ready_i ? '0 : cnt_q;
        state_d = l2_req_ready_i ? (flush_i ? DRAIN : FILL) : (flush_i ? IDLE : REQ);
      end
      FILL: begin
        if (l2_beat_valid_i) begin
          cnt_d = cnt_q + CW'(1);
          if (!flush_i) buf_d[int'(cnt_q)*BEAT_W +: BEAT_W] = l2_beat_data_i;
        end
        state_d = flush_i ? (last_beat ? IDLE : DRAIN) : (last_beat ? WRITE : FILL);
      end
      WRITE: begin
        mem_req_o     = victim_q;
        mem_we_o      = 1'b1;
        refill_done_o = 1'b1;
        refill_way_o  = victim_q;
        rr_d    = use_rr_q ? ((rr_q << 1) | (rr_q >> (N_WAY - 1))) : rr_q;
        state_d = IDLE;
      end
      DRAIN: begin
        cnt_d   = l2_beat_valid_i ? cnt_q + CW'(1) : cnt_q;
        state_d = last_beat ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// tb_sargantana_icache_refill_ctrl: randomized refills checked against a transaction-level victim/line model
module tb_sargantana_icache_refill_ctrl;
  localparam int N_WAY = 4, LINE_W = 256, BEAT_W = 64, IDX_W = 7, BEATS = LINE_W / BEAT_W;
  logic clk = 1'b0, rstn = 1'b1;
  logic miss_valid = 1'b0, flush = 1'b0, req_ready = 1'b0, beat_valid = 1'b0;
  logic [IDX_W-1:0] miss_idx = '0;
  logic [N_WAY-1:0] way_valid = '0;
  logic [BEAT_W-1:0] beat_data = '0;
  logic miss_ready, req_valid, mem_we, refill_done;
  logic [IDX_W-1:0] req_idx, mem_addr;
  logic [N_WAY-1:0] mem_req, refill_way;
  logic [LINE_W-1:0] mem_data;
  int n_chk = 0, n_pass = 0, we_cnt = 0, rr_way = 0;

  sargantana_icache_refill_ctrl #(.N_WAY(N_WAY), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
    .miss_idx_i(miss_idx), .way_valid_i(way_valid), .flush_i(flush),
    .l2_req_valid_o(req_valid), .l2_req_ready_i(req_ready), .l2_req_idx_o(req_idx),
    .l2_beat_valid_i(beat_valid), .l2_beat_data_i(beat_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .refill_done_o(refill_done), .refill_way_o(refill_way));

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs();
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_way", refill_way, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
  endtask

  task automatic gap(input int max_gap, input bit noisy_flush);
    repeat ($urandom_range(0, max_gap)) begin
      beat_valid = 1'b0;
      flush = noisy_flush ? 1'($urandom) : 1'b0;
      @(negedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic drain(input int n, input int w0, input int max_gap);
    for (int b = 0; b < n; b++) begin
      gap(max_gap, 1'b1);
      chk("drain_busy", miss_ready, 0);
      beat_valid = 1'b1;
      beat_data = {$urandom, $urandom};
      @(negedge clk); #1;
      beat_valid = 1'b0;
    end
    chk("drain_done", miss_ready, 1);
    chk("drain_no_write", we_cnt - w0, 0);
  endtask

  // mode: 0 normal, 1 flush in REQ w/o ready, 2 flush in REQ with ready,
  // 3 flush in FILL after beat 1, 4 reset in FILL after beat 1, 5 flush with beat 1
  task automatic refill(input logic [IDX_W-1:0] idx, input logic [N_WAY-1:0] wv, input int mode, input int max_gap);
    logic [BEAT_W-1:0] beats[$];
    logic [LINE_W-1:0] line;
    int way, w0;
    bit use_rr;
    w0 = we_cnt;
    way = -1;
    for (int i = 0; i < N_WAY; i++) if (!wv[i] && way < 0) way = i;
    use_rr = way < 0;
    if (use_rr) way = rr_way;
    miss_valid = 1'b1; miss_idx = idx; way_valid = wv;
    #1 chk("miss_ready", miss_ready, 1);
    @(negedge clk);
    miss_valid = 1'b0; miss_idx = IDX_W'($urandom); way_valid = N_WAY'($urandom);
    #1;
    chk("req_valid", req_valid, 1);
    chk("req_idx", req_idx, idx);
    chk("busy", miss_ready, 0);
    repeat ($urandom_range(0, max_gap)) begin
      beat_valid = 1'($urandom);
      @(negedge clk); #1;
      chk("req_hold", req_valid, 1);
      chk("req_idx_hold", req_idx, idx);
    end
    beat_valid = 1'b0;
    if (mode == 1) begin
      flush = 1'b1;
      @(negedge clk); #1;
      flush = 1'b0;
      chk("req_flush_idle", miss_ready, 1);
      chk("req_flush_noreq", req_valid, 0);
      return;
    end
    req_ready = 1'b1; flush = mode == 2;
    @(negedge clk); #1;
    req_ready = 1'b0; flush = 1'b0;
    chk("req_dropped", req_valid, 0);
    if (mode == 2) begin
      drain(BEATS, w0, max_gap);
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      gap(max_gap, 1'b0);
      chk("fill_no_write", mem_we, 0);
      if (mode == 3 && b == 2) begin
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        drain(BEATS - 2, w0, max_gap);
        return;
      end
      if (mode == 4 && b == 2) begin
        rstn = 1'b0;
        #1 check_reset_outputs();
        rr_way = 0;
        @(negedge clk); #1;
        rstn = 1'b1;
        return;
      end
      beats.push_back({$urandom, $urandom});
      beat_valid = 1'b1; beat_data = beats[b];
      flush = mode == 5 && b == 1;
      @(negedge clk); #1;
      beat_valid = 1'b0;
      if (flush) begin
        flush = 1'b0;
        drain(BEATS - 2, w0, max_gap);
        return;
      end
    end
    line = '0;
    foreach (beats[b]) line |= LINE_W'(beats[b]) << (b * BEAT_W);
    flush = 1'($urandom);
    #1;
    chk("wr_we", mem_we, 1);
    chk("wr_req", mem_req, N_WAY'(1) << way);
    chk("wr_done", refill_done, 1);
    chk("wr_way", refill_way, N_WAY'(1) << way);
    chk("wr_addr", mem_addr, idx);
    chk("wr_data", mem_data, line);
    @(negedge clk); #1;
    flush = 1'b0;
    chk("post_done", refill_done, 0);
    chk("post_ready", miss_ready, 1);
    chk("one_write", we_cnt - w0, 1);
    if (use_rr) rr_way = (rr_way + 1) % N_WAY;
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    refill(7'h12, 4'b1111, 0, 0);
    refill(7'h21, 4'b1011, 0, 0);
    repeat (5) refill(IDX_W'($urandom), 4'b1111, 0, 0);
    refill(7'h05, 4'b1111, 3, 0);
    refill(7'h06, 4'b0110, 0, 1);
    refill(7'h07, 4'b1111, 1, 0);
    refill(7'h08, 4'b1111, 2, 0);
    refill(7'h09, 4'b1111, 5, 0);
    refill(7'h0a, 4'b1111, 0, 2);
    refill(7'h0b, 4'b1111, 4, 3);
    refill(7'h0c, 4'b1111, 0, 3);
    for (int t = 0; t < 60; t++) begin
      int m;
      m = $urandom_range(0, 9);
      refill(IDX_W'($urandom), $urandom_range(0, 1) ? 4'b1111 : N_WAY'($urandom), m > 5 ? 0 : m, 3);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
